phase_unwrap_tracker: RTL and testbench
=======================================

Name: phase_unwrap_tracker

Overview:
- Sits directly downstream of the vectoring CORDIC pipeline and consumes its enable pulse, wrapped angle (Q8.24, range [0, 2π)) and scaled magnitude (Q8.24).
- Produces the wrapped per-sample phase increment in [-π, π), an unwrapped phase accumulator, a block-averaged increment (the instantaneous frequency estimate for the ANC tone tracker) and a lock indication.
- Low-magnitude samples are squelched.

Parameters:
- AVG_LOG2, 4: average over 2^AVG_LOG2 accepted increments.
- ACC_W, 48: unwrapped phase accumulator width, signed, fraction 24 bits.
- LOCK_CNT, 8: consecutive accepted increments required before lock asserts.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable_in  in  1  sample strobe from the CORDIC
- theta_in  in  32  angle, signed Q8.24, nominal [0, 2π)
- mag_in  in  32  magnitude, signed Q8.24
- mag_thresh  in  32  squelch threshold, Q8.24, quasi-static
- valid_out  out  1  one-cycle pulse, new increment available
- delta_out  out  32  wrapped increment, Q8.24, in [-π, π)
- phase_acc_out  out  ACC_W  unwrapped phase, Q(ACC_W-24).24
- avg_valid_out  out  1  one-cycle pulse, new average available
- avg_out  out  32  mean increment, Q8.24
- lock_out  out  1  tracking lock
- sat_out  out  1  sticky accumulator-saturation flag (see Optional Feature)

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high. Every output goes to 0. Internal state is cleared: FSM=IDLE, prev_theta=0, sum=0, avg_cnt=0, lock_cnt=0.
- Constants: PI=0x03243F6B, TWO_PI=0x06487ED6, both Q8.24.
- Accept rule: a sample is accepted when enable_in=1 and mag_in >= mag_thresh (signed compare). When enable_in=0 nothing changes, and both pulse outputs return to 0.
- FSM IDLE:
  - Accepted sample: prev_theta<=theta_in; phase_acc<=sign-extended theta_in; go to TRACK.
  - No valid_out is issued for this priming sample.
- FSM TRACK, accepted sample:
  - Compute d = theta_in - prev_theta at 33 bits.
  - If d >= PI, then d -= TWO_PI; else if d < -PI, then d += TWO_PI. Truncate to 32 bits. d equal to exactly +PI maps to -PI.
  - Next cycle: valid_out=1, delta_out=d.
  - Update prev_theta<=theta_in and phase_acc<=phase_acc + sext(d); the accumulator wraps modulo 2^ACC_W.
  - Latency: 1 cycle from enable_in to valid_out.
- Averaging:
  - sum is 32+AVG_LOG2+1 bits, signed. An accepted increment adds d and increments avg_cnt.
  - When avg_cnt reaches 2^AVG_LOG2-1 before the add: avg_out <= (sum+d) >>> AVG_LOG2 (arithmetic, truncation toward -∞), avg_valid_out=1 in the same cycle as valid_out, then sum<=0 and avg_cnt<=0.
- Lock:
  - lock_cnt saturates at LOCK_CNT and counts accepted increments.
  - lock_out=1 when lock_cnt==LOCK_CNT, registered, and asserts in the same cycle as the LOCK_CNT-th valid_out.
- Squelch: enable_in=1 with mag_in < mag_thresh, in any state:
  - FSM goes to IDLE; sum, avg_cnt, lock_cnt and lock_out are cleared; no pulses are issued.
  - phase_acc_out and avg_out hold their values.
- Out-of-range theta_in is not checked; the wrap rule still applies.
- Reset mid-operation: reset has priority over enable_in in the same cycle.

Optional Feature:
- Macro: PHASE_ACC_SAT_EN.
- Defined:
  - phase_acc saturates at the signed ACC_W max/min instead of wrapping.
  - sat_out is set on any saturating add and stays set until reset.
  - Priming from IDLE overwrites phase_acc but does not clear sat_out.
- Undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - sat_out is tied to 0.

Decomposition:
- Shared package cordic_pkg:
  - typedef q8_24_t (logic signed [31:0]).
  - Constants PI_Q24, TWO_PI_Q24, HALF_PI_Q24, THREE_HALF_PI_Q24. The existing CORDIC wrapper migrates to these same constants.
- One combinational sub-module phase_wrap: theta_in, prev_theta in; wrapped 32-bit d out. It is reused by the verification model.
- The FSM, averager and lock counter stay in the top module.

Test Plan:
1. Reset, then idle with no enable_in: all outputs are 0; after reset release with enable_in=0 for 10 cycles, outputs stay 0.
2. mag_thresh=0x00100000, mag_in=0x01000000; theta = k·0x00400000 for k=0..17:
   - No valid_out for k=0.
   - 17 valid_out pulses, each with delta_out=0x00400000.
   - lock_out rises with the 8th pulse.
   - avg_valid_out with avg_out=0x00400000 on the 16th pulse.
   - phase_acc_out=0x4400000 after the last pulse.
3. Wrap-around: prev theta=0x06000000, next=0x00200000 gives delta_out=0x00687ED6.
4. Exact π: prev theta=0, next=0x03243F6B gives delta_out=0xFCDBC095 (-π).
5. Squelch: after lock, one sample with mag_in=0x00080000:
   - lock_out=0, no pulse.
   - The next good sample primes without valid_out; the one after produces valid_out; lock is re-acquired after 8 more accepted increments.
6. With PHASE_ACC_SAT_EN and ACC_W=32: feed a constant delta of +0x03000000 repeatedly; phase_acc_out clamps at 0x7FFFFFFF and sat_out=1. Without the macro, the accumulator wraps negative and sat_out stays 0. Reset mid-run clears all outputs the next cycle.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC / phase-tracking types and Q8.24 angle constants.
// Used by the CORDIC wrapper and by phase_unwrap_tracker.
package cordic_pkg;

  typedef logic signed [31:0] q8_24_t;

  localparam int Q_FRAC = 24;

  localparam q8_24_t PI_Q24            = 32'sh0324_3F6B;
  localparam q8_24_t TWO_PI_Q24        = 32'sh0648_7ED6;
  localparam q8_24_t HALF_PI_Q24       = 32'sh0192_1FB5;
  localparam q8_24_t THREE_HALF_PI_Q24 = 32'sh04B6_5F20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } track_state_t;

endpackage

// File: rtl/phase_wrap.sv
// Combinational phase difference wrapped into [-pi, pi) in Q8.24.
// An exact +pi difference lands on -pi so the interval stays half-open.
module phase_wrap
  import cordic_pkg::*;
(
  input  q8_24_t theta,
  input  q8_24_t prev_theta,
  output q8_24_t delta
);

  localparam logic signed [32:0] PI_33     = 33'(PI_Q24);
  localparam logic signed [32:0] NEG_PI_33 = -33'(PI_Q24);
  localparam logic signed [32:0] TWO_PI_33 = 33'(TWO_PI_Q24);

  logic signed [32:0] diff;
  logic signed [32:0] wrapped;

  always_comb begin
    diff    = 33'(theta) - 33'(prev_theta);
    wrapped = diff;
    if (diff >= PI_33) begin
      wrapped = diff - TWO_PI_33;
    end else if (diff < NEG_PI_33) begin
      wrapped = diff + TWO_PI_33;
    end
    delta = 32'(wrapped);
  end

endmodule

// File: rtl/phase_unwrap_tracker.sv
// Phase unwrapper / frequency estimator behind the vectoring CORDIC.
// Optional macro PHASE_ACC_SAT_EN: saturating accumulator with sticky sat_out.
module phase_unwrap_tracker
  import cordic_pkg::*;
#(
  parameter int AVG_LOG2 = 4,
  parameter int ACC_W    = 48,
  parameter int LOCK_CNT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_in,
  input  logic [31:0]      theta_in,
  input  logic [31:0]      mag_in,
  input  logic [31:0]      mag_thresh,
  output logic             valid_out,
  output logic [31:0]      delta_out,
  output logic [ACC_W-1:0] phase_acc_out,
  output logic             avg_valid_out,
  output logic [31:0]      avg_out,
  output logic             lock_out,
  output logic             sat_out
);

  localparam int SUM_W = 32 + AVG_LOG2 + 1;
  localparam int LCW   = $clog2(LOCK_CNT + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CNT);

  track_state_t state_reg, state_next;

  q8_24_t                   prev_theta_reg;
  q8_24_t                   delta_wrap;
  q8_24_t                   delta_reg;
  q8_24_t                   avg_reg;
  q8_24_t                   avg_next;
  logic signed [ACC_W-1:0]  phase_acc_reg;
  logic signed [ACC_W-1:0]  acc_step;
  logic signed [SUM_W-1:0]  sum_reg;
  logic signed [SUM_W-1:0]  sum_plus;
  logic [AVG_LOG2-1:0]      avg_cnt_reg;
  logic [LCW-1:0]           lock_cnt_reg;
  logic [LCW-1:0]           lock_cnt_inc;
  logic                     valid_reg;
  logic                     avg_valid_reg;
  logic                     lock_reg;
  logic                     accept;
  logic                     squelch;
  logic                     prime;
  logic                     step;

  phase_wrap u_wrap (
    .theta      (theta_in),
    .prev_theta (prev_theta_reg),
    .delta      (delta_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (squelch) begin
      state_next = ST_IDLE;
    end else if (accept) begin
      state_next = ST_TRACK;
    end
  end

  always_comb begin
    accept  = enable_in && ($signed(mag_in) >= $signed(mag_thresh));
    squelch = enable_in && !accept;
    prime   = accept && (state_reg == ST_IDLE);
    step    = accept && (state_reg == ST_TRACK);
  end

  always_comb begin
    sum_plus     = sum_reg + SUM_W'(delta_wrap);
    avg_next     = 32'(sum_plus >>> AVG_LOG2);
    lock_cnt_inc = (lock_cnt_reg == LOCK_MAX) ? lock_cnt_reg : lock_cnt_reg + 1'b1;
  end

`ifdef PHASE_ACC_SAT_EN
  logic signed [ACC_W:0] acc_wide;
  logic                  acc_ovf;
  logic                  sat_reg;

  // One guard bit: overflow shows up as the top two bits disagreeing.
  always_comb begin
    acc_wide = (ACC_W+1)'(phase_acc_reg) + (ACC_W+1)'(delta_wrap);
    acc_ovf  = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
    if (!acc_ovf) begin
      acc_step = acc_wide[ACC_W-1:0];
    end else if (acc_wide[ACC_W]) begin
      acc_step = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_step = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_reg <= 1'b0;
    end else if (step && acc_ovf) begin
      sat_reg <= 1'b1;
    end
  end

  assign sat_out = sat_reg;
`else
  always_comb begin
    acc_step = phase_acc_reg + ACC_W'(delta_wrap);
  end

  assign sat_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_theta_reg <= '0;
      phase_acc_reg  <= '0;
      sum_reg        <= '0;
      avg_cnt_reg    <= '0;
      lock_cnt_reg   <= '0;
      valid_reg      <= 1'b0;
      delta_reg      <= '0;
      avg_valid_reg  <= 1'b0;
      avg_reg        <= '0;
      lock_reg       <= 1'b0;
    end else begin
      valid_reg     <= 1'b0;
      avg_valid_reg <= 1'b0;
      if (squelch) begin
        // Tracking history is untrustworthy; keep phase and last average.
        sum_reg      <= '0;
        avg_cnt_reg  <= '0;
        lock_cnt_reg <= '0;
        lock_reg     <= 1'b0;
      end else if (prime) begin
        prev_theta_reg <= theta_in;
        phase_acc_reg  <= ACC_W'($signed(theta_in));
      end else if (step) begin
        prev_theta_reg <= theta_in;
        phase_acc_reg  <= acc_step;
        valid_reg      <= 1'b1;
        delta_reg      <= delta_wrap;
        if (avg_cnt_reg == '1) begin
          avg_reg       <= avg_next;
          avg_valid_reg <= 1'b1;
          sum_reg       <= '0;
          avg_cnt_reg   <= '0;
        end else begin
          sum_reg     <= sum_plus;
          avg_cnt_reg <= avg_cnt_reg + 1'b1;
        end
        lock_cnt_reg <= lock_cnt_inc;
        lock_reg     <= (lock_cnt_inc == LOCK_MAX);
      end
    end
  end

  assign valid_out     = valid_reg;
  assign delta_out     = delta_reg;
  assign phase_acc_out = phase_acc_reg;
  assign avg_valid_out = avg_valid_reg;
  assign avg_out       = avg_reg;
  assign lock_out      = lock_reg;

endmodule

// File: tb/tb_phase_unwrap_tracker.sv
// Self-checking bench for phase_unwrap_tracker (ACC_W=32 so saturation is reachable).
// Expectations adapt to whether PHASE_ACC_SAT_EN is defined.
module tb_phase_unwrap_tracker;

  localparam int ACC_W = 32;
  localparam logic [31:0] GOOD_MAG = 32'h0100_0000;
  localparam logic [31:0] BAD_MAG  = 32'h0008_0000;
`ifdef PHASE_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             enable_in;
  logic [31:0]      theta_in;
  logic [31:0]      mag_in;
  logic [31:0]      mag_thresh;
  logic             valid_out;
  logic [31:0]      delta_out;
  logic [ACC_W-1:0] phase_acc_out;
  logic             avg_valid_out;
  logic [31:0]      avg_out;
  logic             lock_out;
  logic             sat_out;

  always #5 clk = ~clk;

  phase_unwrap_tracker #(
    .AVG_LOG2 (4),
    .ACC_W    (ACC_W),
    .LOCK_CNT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_in     (enable_in),
    .theta_in      (theta_in),
    .mag_in        (mag_in),
    .mag_thresh    (mag_thresh),
    .valid_out     (valid_out),
    .delta_out     (delta_out),
    .phase_acc_out (phase_acc_out),
    .avg_valid_out (avg_valid_out),
    .avg_out       (avg_out),
    .lock_out      (lock_out),
    .sat_out       (sat_out)
  );

  typedef struct packed {
    logic        en;
    logic [31:0] theta;
    logic [31:0] mag;
    logic        exp_valid;
    logic [31:0] exp_delta;
    logic [31:0] exp_acc;
    logic        exp_lock;
    logic        exp_avg_valid;
    logic [31:0] exp_avg;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [0:127];
  int   n_vec;
  vec_t exp_q [$];
  vec_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;

  function automatic vec_t mk(input logic en, input logic [31:0] th, input logic [31:0] mag,
                              input logic ev, input logic [31:0] ed, input logic [31:0] ea,
                              input logic el, input logic eav, input logic [31:0] eavg,
                              input logic es);
    vec_t v;
    v.en = en; v.theta = th; v.mag = mag; v.exp_valid = ev; v.exp_delta = ed;
    v.exp_acc = ea; v.exp_lock = el; v.exp_avg_valid = eav; v.exp_avg = eavg; v.exp_sat = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop one expected record for every valid_out pulse.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {127'd0, valid_out}, 128'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("pulse theta=0x%08h delta=0x%08h acc=0x%08h lock=%0b avg_v=%0b",
                 mon_e.theta, delta_out, phase_acc_out, lock_out, avg_valid_out);
        check("delta", {96'd0, delta_out}, {96'd0, mon_e.exp_delta});
        check("phase_acc", {96'd0, phase_acc_out}, {96'd0, mon_e.exp_acc});
        check("lock", {127'd0, lock_out}, {127'd0, mon_e.exp_lock});
        check("avg_valid", {127'd0, avg_valid_out}, {127'd0, mon_e.exp_avg_valid});
        check("sat", {127'd0, sat_out}, {127'd0, mon_e.exp_sat});
        if (mon_e.exp_avg_valid) begin
          check("avg", {96'd0, avg_out}, {96'd0, mon_e.exp_avg});
        end
      end
    end else if (avg_valid_out === 1'b1) begin
      check("stray_avg_valid", {127'd0, avg_valid_out}, 128'd0);
    end
  end

  task automatic apply(input vec_t v);
    enable_in = v.en;
    theta_in  = v.theta;
    mag_in    = v.mag;
    if (v.exp_valid) exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (!v.exp_valid) begin
      $display("quiet en=%0b theta=0x%08h acc=0x%08h lock=%0b", v.en, v.theta, phase_acc_out, lock_out);
      check("no_pulse", {127'd0, valid_out}, 128'd0);
      check("acc_quiet", {96'd0, phase_acc_out}, {96'd0, v.exp_acc});
      check("lock_quiet", {127'd0, lock_out}, {127'd0, v.exp_lock});
      check("sat_quiet", {127'd0, sat_out}, {127'd0, v.exp_sat});
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < n_vec; i++) apply(vecs[i]);
  endtask

  longint      acc_m;
  logic        sat_m;
  logic [31:0] th;

  initial begin
    reset      = 1'b1;
    enable_in  = 1'b0;
    theta_in   = '0;
    mag_in     = '0;
    mag_thresh = 32'h0010_0000;

    // Reset and quiet idle.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {28'd0, valid_out, delta_out, phase_acc_out, avg_valid_out, avg_out, lock_out, sat_out}, 128'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle_outputs", {28'd0, valid_out, delta_out, phase_acc_out, avg_valid_out, avg_out, lock_out, sat_out}, 128'd0);
    end

    // Ramp, wrap-around, exact pi, squelch and re-lock.
    n_vec = 0;
    for (int k = 0; k <= 17; k++) begin
      vecs[n_vec++] = mk(1'b1, 32'(k) * 32'h0040_0000, GOOD_MAG, k != 0, 32'h0040_0000,
                         32'(k) * 32'h0040_0000, k >= 8, k == 16, 32'h0040_0000, 1'b0);
    end
    vecs[n_vec++] = mk(1'b1, 32'h0600_0000, GOOD_MAG, 1'b1, 32'h01C0_0000, 32'h0600_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    vecs[n_vec++] = mk(1'b1, 32'h0020_0000, GOOD_MAG, 1'b1, 32'h0068_7ED6, 32'h0668_7ED6, 1'b1, 1'b0, 32'h0, 1'b0);
    vecs[n_vec++] = mk(1'b1, 32'h0000_0000, GOOD_MAG, 1'b1, 32'hFFE0_0000, 32'h0648_7ED6, 1'b1, 1'b0, 32'h0, 1'b0);
    vecs[n_vec++] = mk(1'b1, 32'h0324_3F6B, GOOD_MAG, 1'b1, 32'hFCDB_C095, 32'h0324_3F6B, 1'b1, 1'b0, 32'h0, 1'b0);
    vecs[n_vec++] = mk(1'b1, 32'h0050_0000, BAD_MAG, 1'b0, 32'h0, 32'h0324_3F6B, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[n_vec++] = mk(1'b1, 32'h0100_0000, GOOD_MAG, 1'b0, 32'h0, 32'h0100_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      vecs[n_vec++] = mk(1'b1, 32'h0100_0000 + 32'(j) * 32'h0010_0000, GOOD_MAG, 1'b1, 32'h0010_0000,
                         32'h0100_0000 + 32'(j) * 32'h0010_0000, j >= 8, 1'b0, 32'h0, 1'b0);
    end
    vecs[n_vec++] = mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0180_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    vecs[n_vec++] = mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0180_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    run_table();
    check("queue_drained_1", 128'(exp_q.size()), 128'd0);

    // Constant +0x03000000 increments: saturate or wrap depending on build.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_vec = 0;
    acc_m = 0;
    sat_m = 1'b0;
    vecs[n_vec++] = mk(1'b1, 32'h0, GOOD_MAG, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 50; k++) begin
      th    = 32'((longint'(k) * 64'h0300_0000) % 64'h0648_7ED6);
      acc_m = acc_m + 64'h0300_0000;
      if (SAT_EN && acc_m > 64'h7FFF_FFFF) begin
        acc_m = 64'h7FFF_FFFF;
        sat_m = 1'b1;
      end
      vecs[n_vec++] = mk(1'b1, th, GOOD_MAG, 1'b1, 32'h0300_0000, 32'(acc_m), k >= 8,
                         (k % 16) == 0, 32'h0300_0000, sat_m);
    end
    run_table();

    // Reset colliding with an accepted sample wins.
    enable_in = 1'b1;
    theta_in  = 32'h0020_0000;
    mag_in    = GOOD_MAG;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    $display("midrun reset acc=0x%08h sat=%0b", phase_acc_out, sat_out);
    check("reset_midrun", {28'd0, valid_out, delta_out, phase_acc_out, avg_valid_out, avg_out, lock_out, sat_out}, 128'd0);
    reset = 1'b0;
    apply(mk(1'b1, 32'h0100_0000, GOOD_MAG, 1'b0, 32'h0, 32'h0100_0000, 1'b0, 1'b0, 32'h0, 1'b0));
    apply(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0100_0000, 1'b0, 1'b0, 32'h0, 1'b0));
    apply(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0100_0000, 1'b0, 1'b0, 32'h0, 1'b0));
    check("queue_drained_2", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
